// File: rtl/and2_tester.sv
// and2_tester: sequential stimulus/response checker for a 2-input AND gate.
// Sweeps {a,b} through 00,01,10,11 LOOPS times, holds each vector for
// SETTLE_CYCLES+1 cycles, samples y_in in the last cycle and counts mismatches.
//
// Parameters:
//   SETTLE_CYCLES  cycles each vector is held before sampling (>=1)
//   LOOPS          full 4-vector sweeps per run (>=1)
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          run request, sampled only in IDLE
//   y_in           gate output under test
//   a_out, b_out   registered drive to the gate inputs
//   busy           high from start acceptance through the done cycle
//   done           one-cycle end-of-run pulse
//   pass           last completed run had zero mismatches
//   err_count      mismatch count, saturating at 255
//   vec_idx        index of the vector currently driven
// Optional feature (macro AND2_TESTER_FAIL_CAPTURE_EN):
//   fail_valid     first mismatch of the run has been seen
//   fail_vec       vec_idx of that first mismatch
module and2_tester #(
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned LOOPS         = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       y_in,
   output logic       a_out,
   output logic       b_out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [7:0] err_count,
   output logic [1:0] vec_idx
`ifdef AND2_TESTER_FAIL_CAPTURE_EN
   ,
   output logic       fail_valid,
   output logic [1:0] fail_vec
`endif
);

   localparam int unsigned CNT_W  = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned LOOP_W = (LOOPS > 1) ? $clog2(LOOPS) : 1;
   localparam logic [CNT_W-1:0]  SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);
   localparam logic [LOOP_W-1:0] LOOP_LAST   = LOOP_W'(LOOPS - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

   state_t            state, state_d;
   logic [CNT_W-1:0]  settle_cnt, settle_cnt_d;
   logic [LOOP_W-1:0] loop_cnt, loop_cnt_d;
   logic              a_d, b_d, busy_d, done_d, pass_d;
   logic [7:0]        err_d, err_next;
   logic [1:0]        vec_d, vec_next;
   logic              mismatch;
`ifdef AND2_TESTER_FAIL_CAPTURE_EN
   logic              fail_valid_d;
   logic [1:0]        fail_vec_d;
`endif

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         settle_cnt <= '0;
         loop_cnt   <= '0;
         a_out      <= 1'b0;
         b_out      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= 8'd0;
         vec_idx    <= 2'd0;
`ifdef AND2_TESTER_FAIL_CAPTURE_EN
         fail_valid <= 1'b0;
         fail_vec   <= 2'd0;
`endif
      end else begin
         state      <= state_d;
         settle_cnt <= settle_cnt_d;
         loop_cnt   <= loop_cnt_d;
         a_out      <= a_d;
         b_out      <= b_d;
         busy       <= busy_d;
         done       <= done_d;
         pass       <= pass_d;
         err_count  <= err_d;
         vec_idx    <= vec_d;
`ifdef AND2_TESTER_FAIL_CAPTURE_EN
         fail_valid <= fail_valid_d;
         fail_vec   <= fail_vec_d;
`endif
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state;
      settle_cnt_d = settle_cnt;
      loop_cnt_d   = loop_cnt;
      a_d          = a_out;
      b_d          = b_out;
      busy_d       = busy;
      done_d       = 1'b0;
      pass_d       = pass;
      err_d        = err_count;
      vec_d        = vec_idx;
`ifdef AND2_TESTER_FAIL_CAPTURE_EN
      fail_valid_d = fail_valid;
      fail_vec_d   = fail_vec;
`endif
      // Case inequality so an X/Z response is treated as a mismatch
      mismatch = (y_in !== (a_out & b_out));
      err_next = (mismatch && (err_count != 8'd255)) ? err_count + 8'd1 : err_count;
      vec_next = vec_idx + 2'd1;

      case (state)
         IDLE: begin
            a_d = 1'b0;
            b_d = 1'b0;
            if (start) begin
               vec_d        = 2'd0;
               err_d        = 8'd0;
               pass_d       = 1'b0;
               settle_cnt_d = SETTLE_LOAD;
               loop_cnt_d   = '0;
               busy_d       = 1'b1;
`ifdef AND2_TESTER_FAIL_CAPTURE_EN
               fail_valid_d = 1'b0;
               fail_vec_d   = 2'd0;
`endif
               state_d      = SETTLE;
            end
         end
         SETTLE: begin
            if (settle_cnt == CNT_W'(1)) state_d = SAMPLE;
            else settle_cnt_d = settle_cnt - CNT_W'(1);
         end
         SAMPLE: begin
            err_d = err_next;
`ifdef AND2_TESTER_FAIL_CAPTURE_EN
            if (mismatch && !fail_valid) begin
               fail_valid_d = 1'b1;
               fail_vec_d   = vec_idx;
            end
`endif
            if (vec_idx != 2'd3) begin
               vec_d        = vec_next;
               a_d          = vec_next[1];
               b_d          = vec_next[0];
               settle_cnt_d = SETTLE_LOAD;
               state_d      = SETTLE;
            end else if (loop_cnt < LOOP_LAST) begin
               loop_cnt_d   = loop_cnt + LOOP_W'(1);
               vec_d        = 2'd0;
               a_d          = 1'b0;
               b_d          = 1'b0;
               settle_cnt_d = SETTLE_LOAD;
               state_d      = SETTLE;
            end else begin
               // pass uses the count including this final sample
               done_d  = 1'b1;
               pass_d  = (err_next == 8'd0);
               a_d     = 1'b0;
               b_d     = 1'b0;
               state_d = DONE;
            end
         end
         DONE: begin
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: doc/and2_tester.md
# and2_tester

Sequential stimulus/response checker for the switch-level `and2` gate. It drives the gate's `a`/`b` inputs through all four input combinations, waits a programmable settle time, and samples the gate's `y` output. Each sample is compared against the expected AND result, and mismatches are counted. It sits directly around the gate: upstream as its input driver, downstream as the consumer of `y`.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range ≥1.
- `LOOPS`, default 1: number of full 4-vector sweeps per run; legal range ≥1.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start`  in  1  run request; sampled only in IDLE.
- `y_in`  in  1  output of the gate under test.
- `a_out`  out  1  drive to gate input `a` (registered).
- `b_out`  out  1  drive to gate input `b` (registered).
- `busy`  out  1  high from start acceptance until the DONE cycle ends.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  high when the last completed run had zero errors; held until the next start.
- `err_count`  out  8  mismatches in the current or last run; saturates at 255.
- `vec_idx`  out  2  index of the vector currently driven: {a,b} = 00, 01, 10, 11.

## Operation
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Reset values:
  - state = IDLE
  - `a_out` = `b_out` = 0, `vec_idx` = 0
  - `busy` = `done` = `pass` = 0, `err_count` = 0
  - settle counter = 0, loop counter = 0
- IDLE:
  - `a_out` and `b_out` are held at 0.
  - When `start` = 1, load vector 0 ({a,b} = 00), clear `err_count` and `pass`, load settle counter = `SETTLE_CYCLES`, clear loop counter, set `busy`, and go to SETTLE.
- SETTLE:
  - If counter = 1, go to SAMPLE.
  - Otherwise decrement the counter.
- SAMPLE:
  - Expected value = `a_out` & `b_out`.
  - If `y_in` differs from the expected value (case inequality; X or Z counts as a mismatch), increment `err_count`, saturating at 255.
  - If `vec_idx` < 3: advance `vec_idx` and the drive outputs to the next vector, reload the settle counter, and go to SETTLE.
  - If `vec_idx` = 3 and loop counter < `LOOPS`−1: increment the loop counter, wrap to vector 0, and go to SETTLE.
  - Otherwise go to DONE.
- DONE:
  - Assert `done` for one cycle.
  - Set `pass` = (`err_count` == 0), using the final count including the last SAMPLE.
  - Drive `a_out` = `b_out` = 0, clear `busy`, and go to IDLE.
- `start` while `busy` is ignored; no queuing.
- Reset asserted mid-run forces every output to its reset value immediately (asynchronous). The run is lost, and no `done` pulse is produced.

## Timing
- Each vector is driven for exactly `SETTLE_CYCLES`+1 cycles.
- `y_in` is sampled in the last of those cycles, i.e. `SETTLE_CYCLES` full cycles after the vector changed.
- The first vector appears on `a_out`/`b_out` one edge after `start` is accepted.
- `done` is high in the cycle following edge E0 + 4·`LOOPS`·(`SETTLE_CYCLES`+1), where E0 is the edge that accepted `start`.
- `busy` is high from E0 through the `done` cycle inclusive.
- `pass` and `err_count` are valid from the `done` cycle onward and stable until the next accepted start.
- `start` asserted in the DONE cycle is ignored. The earliest new acceptance is in the following IDLE cycle.

## Configuration
- Macro: `AND2_TESTER_FAIL_CAPTURE_EN`.
- When defined, two extra outputs are added:
  - `fail_valid` (1 bit): set on the first mismatch of a run.
  - `fail_vec` (2 bits): the `vec_idx` at which that first mismatch occurred.
  - Both reset to 0, are cleared on start acceptance, and hold until the next start.
- When undefined, these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Correct `and2` attached, defaults, `start` at edge E0:
  - `done` pulse 12 cycles after E0, `pass` = 1, `err_count` = 0.
  - `vec_idx` steps 0→1→2→3, each held 3 cycles.
- `y_in` stuck at 1, `LOOPS` = 3: `err_count` = 9, `pass` = 0; with the macro, `fail_vec` = 0 and `fail_valid` = 1.
- `y_in` stuck at 0, `LOOPS` = 1: `err_count` = 1; with the macro, `fail_vec` = 3.
- `y_in` = Z, `LOOPS` = 100, `SETTLE_CYCLES` = 1: `err_count` saturates at 255 and `pass` = 0. `done` arrives 800 cycles after E0.
- `start` pulsed again while `busy`: ignored, with timing identical to a single start. A second start after `done` clears `err_count` to 0 on acceptance.
- Deassert `rst_n` during vector 2 of a run:
  - All outputs return to reset values asynchronously, with no `done` pulse.
  - After release, a new start completes normally with `pass` = 1.
